// File: rtl/exe_pkg.sv
// Shared types and constants for the execution unit and its issue controller.
package exe_pkg;

  typedef enum logic [1:0] {
    OP_SHL  = 2'b00,
    OP_GT   = 2'b01,
    OP_RSV2 = 2'b10,
    OP_RSV3 = 2'b11
  } oper_t;

  localparam logic [2:0] STAT_OK      = 3'b000;
  localparam logic [2:0] STAT_INVALID = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } issue_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, holding once the maximum is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue-side controller: takes one command over valid/ready, drives the exe unit,
// captures its result after EXE_LAT extra cycles and returns it over a response
// handshake. Counts non-OK statuses in a saturating counter.
module exe_issue_ctrl
  import exe_pkg::*;
#(
  parameter int ARG_BYTES = 4,
  parameter int EXE_LAT   = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rsn,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_oper,
  input  logic [ARG_BYTES-1:0] i_cmd_argA,
  input  logic [ARG_BYTES-1:0] i_cmd_argB,
  output logic [1:0]           o_oper,
  output logic [ARG_BYTES-1:0] o_argA,
  output logic [ARG_BYTES-1:0] o_argB,
  input  logic [ARG_BYTES-1:0] i_result,
  input  logic [2:0]           i_status,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [1:0]           o_rsp_oper,
  output logic [ARG_BYTES-1:0] o_rsp_result,
  output logic [2:0]           o_rsp_status,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_busy
);

  localparam int LAT_W = (EXE_LAT > 0) ? $clog2(EXE_LAT + 1) : 1;

  issue_state_t     state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             cmd_hs;
  logic             rsp_hs;
  logic             capture;

  // In RESP a new command is only taken together with the response, so the
  // operand registers never get overwritten while a result is still pending.
  assign o_cmd_ready = ~i_rsn & ((state == IDLE) | ((state == RESP) & i_rsp_ready));
  assign o_rsp_valid = (state == RESP);
  assign o_busy      = (state != IDLE);
  assign cmd_hs      = i_cmd_valid & o_cmd_ready;
  assign rsp_hs      = o_rsp_valid & i_rsp_ready;
  assign capture     = (state == EXEC) && (lat_cnt == '0);

  // State register.
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE, or RESP -> EXEC back-to-back.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_hs) state_nxt = EXEC;
      EXEC:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = cmd_hs ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers and latency countdown; operands only change on acceptance.
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      o_oper  <= '0;
      o_argA  <= '0;
      o_argB  <= '0;
      lat_cnt <= '0;
    end else if (cmd_hs) begin
      o_oper  <= i_cmd_oper;
      o_argA  <= i_cmd_argA;
      o_argB  <= i_cmd_argB;
      lat_cnt <= LAT_W'(EXE_LAT);
    end else if ((state == EXEC) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Response registers: loaded once per command, stable through RESP.
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      o_rsp_oper   <= '0;
      o_rsp_result <= '0;
      o_rsp_status <= '0;
    end else if (capture) begin
      o_rsp_oper   <= o_oper;
      o_rsp_result <= i_result;
      o_rsp_status <= i_status;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk (i_clk),
    .rst (i_rsn),
    .inc (capture && (i_status != STAT_OK)),
    .cnt (o_err_cnt)
  );

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Bench for exe_issue_ctrl: one instance with EXE_LAT=0 and one with EXE_LAT=3,
// selected by 'sel' and driven through a common set of stimulus signals.
module tb_exe_issue_ctrl;
  import exe_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [1:0]  cmd_oper = '0;
  logic [AW-1:0] cmd_a = '0, cmd_b = '0;
  bit          ferr = 1'b0;

  logic          a_cmd_ready, a_rsp_valid, a_busy, b_cmd_ready, b_rsp_valid, b_busy;
  logic [1:0]    a_oper, a_rsp_oper, b_oper, b_rsp_oper;
  logic [AW-1:0] a_argA, a_argB, a_result, a_rsp_result;
  logic [AW-1:0] b_argA, b_argB, b_result, b_rsp_result;
  logic [2:0]    a_status, a_rsp_status, b_status, b_rsp_status;
  logic [7:0]    a_err, b_err;
  logic [6:0]    a_exe, b_exe;

  // Behavioural exe unit: SHL, GT; reserved opers return A^B with INVALID status.
  function automatic logic [6:0] exe_fn(input logic [1:0] op, input logic [3:0] x,
                                        input logic [3:0] y, input bit fe);
    logic [3:0] r;
    logic [2:0] s;
    s = STAT_OK;
    case (op)
      2'b00:   r = x << y;
      2'b01:   r = (x > y) ? 4'd1 : 4'd0;
      default: begin r = x ^ y; s = STAT_INVALID; end
    endcase
    if (fe) s = STAT_INVALID;
    return {s, r};
  endfunction

  assign a_exe = exe_fn(a_oper, a_argA, a_argB, ferr);
  assign b_exe = exe_fn(b_oper, b_argA, b_argB, ferr);
  assign a_result = a_exe[3:0];
  assign a_status = a_exe[6:4];
  assign b_result = b_exe[3:0];
  assign b_status = b_exe[6:4];

  exe_issue_ctrl #(.ARG_BYTES(AW), .EXE_LAT(0), .ERR_CNT_W(8)) u_a (
    .i_clk(clk), .i_rsn(rst), .i_cmd_valid(cmd_valid && sel == 0), .o_cmd_ready(a_cmd_ready),
    .i_cmd_oper(cmd_oper), .i_cmd_argA(cmd_a), .i_cmd_argB(cmd_b),
    .o_oper(a_oper), .o_argA(a_argA), .o_argB(a_argB), .i_result(a_result), .i_status(a_status),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready && sel == 0), .o_rsp_oper(a_rsp_oper),
    .o_rsp_result(a_rsp_result), .o_rsp_status(a_rsp_status), .o_err_cnt(a_err), .o_busy(a_busy));

  exe_issue_ctrl #(.ARG_BYTES(AW), .EXE_LAT(3), .ERR_CNT_W(8)) u_b (
    .i_clk(clk), .i_rsn(rst), .i_cmd_valid(cmd_valid && sel == 1), .o_cmd_ready(b_cmd_ready),
    .i_cmd_oper(cmd_oper), .i_cmd_argA(cmd_a), .i_cmd_argB(cmd_b),
    .o_oper(b_oper), .o_argA(b_argA), .o_argB(b_argB), .i_result(b_result), .i_status(b_status),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready && sel == 1), .o_rsp_oper(b_rsp_oper),
    .o_rsp_result(b_rsp_result), .o_rsp_status(b_rsp_status), .o_err_cnt(b_err), .o_busy(b_busy));

  wire          cmd_ready  = (sel == 1) ? b_cmd_ready  : a_cmd_ready;
  wire          rsp_valid  = (sel == 1) ? b_rsp_valid  : a_rsp_valid;
  wire [1:0]    rsp_oper   = (sel == 1) ? b_rsp_oper   : a_rsp_oper;
  wire [AW-1:0] rsp_result = (sel == 1) ? b_rsp_result : a_rsp_result;
  wire [2:0]    rsp_status = (sel == 1) ? b_rsp_status : a_rsp_status;
  wire [7:0]    err_cnt    = (sel == 1) ? b_err        : a_err;
  wire          busy       = (sel == 1) ? b_busy       : a_busy;
  wire [AW-1:0] argA       = (sel == 1) ? b_argA       : a_argA;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Present a command, wait for acceptance, then count cycles until rsp_valid.
  // Entered and left at #1 after a rising edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                       output int lat);
    int g;
    cmd_valid = 1'b1; cmd_oper = op; cmd_a = x; cmd_b = y;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = ~x; cmd_b = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] x, y, res;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] x, y;
  } cmd_t;

  vec_t tbl[8];
  cmd_t q[$];

  initial begin
    int lat, n, g, sent, rcvd, nerr, seen, sel_e;
    tbl[0] = '{2'b01, 4'd5,  4'd3, 4'd1,  3'd0};
    tbl[1] = '{2'b00, 4'd1,  4'd2, 4'd4,  3'd0};
    tbl[2] = '{2'b00, 4'd3,  4'd1, 4'd6,  3'd0};
    tbl[3] = '{2'b00, 4'd15, 4'd1, 4'd14, 3'd0};
    tbl[4] = '{2'b00, 4'd1,  4'd4, 4'd0,  3'd0};
    tbl[5] = '{2'b01, 4'd7,  4'd7, 4'd0,  3'd0};
    tbl[6] = '{2'b10, 4'd3,  4'd5, 4'd6,  3'd1};
    tbl[7] = '{2'b11, 4'd9,  4'd9, 4'd0,  3'd1};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_cmd_ready", a_cmd_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_exe_out", {a_oper, a_argA, a_argB}, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_cmd_ready", b_cmd_ready, 0);
    chk("rst_b_rsp", {b_rsp_valid, b_rsp_oper, b_rsp_result, b_rsp_status}, 0);
    chk("rst_b_exe_out", {b_oper, b_argA, b_argB}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_a_cmd_ready", a_cmd_ready, 1);

    // Table of vectors on the zero-latency instance.
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].op, tbl[i].x, tbl[i].y, lat);
      chk("lat0_latency", lat, 1);
      chk("lat0_result", rsp_result, tbl[i].res);
      chk("lat0_status", rsp_status, tbl[i].st);
      chk("lat0_oper", rsp_oper, tbl[i].op);
      if (i == 0) chk("lat0_err_first", err_cnt, 0);
      take_rsp();
      chk("lat0_back_idle", busy, 0);
    end
    chk("lat0_err_after_tbl", err_cnt, 2);

    // Saturation: clear by reset, then 300 back-to-back erroring commands.
    rst = 1'b1; #1;
    chk("sat_cleared", a_err, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    ferr = 1'b1; cmd_valid = 1'b1; cmd_oper = 2'b01; cmd_a = 4'd3; cmd_b = 4'd1;
    rsp_ready = 1'b1;
    n = 0; g = 0;
    while (n < 300 && g < 2000) begin
      @(negedge clk); g++;
      if (rsp_valid && rsp_ready) begin
        n++;
        chk("sat_count", err_cnt, (n > 255) ? 255 : n);
      end
    end
    chk("sat_responses", n, 300);
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    g = 0;
    while (!rsp_valid && g < 20) begin @(posedge clk); #1; g++; end
    take_rsp();
    ferr = 1'b0;
    chk("sat_hold", err_cnt, 255);

    // EXE_LAT=3: operands held while the command inputs toggle.
    sel = 1;
    cmd_valid = 1'b1; cmd_oper = 2'b01; cmd_a = 4'd2; cmd_b = 4'd7;
    @(negedge clk);
    chk("lat3_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      cmd_a = cmd_a ^ 4'hF;
      chk("lat3_argA_hold", argA, 2);
      chk("lat3_no_ready", cmd_ready, 0);
      @(posedge clk); #1; lat++;
    end
    chk("lat3_latency", lat, 4);
    chk("lat3_result", rsp_result, 0);
    chk("lat3_status", rsp_status, 0);
    take_rsp();

    // Stalled response, then simultaneous response and command handshakes.
    issue(2'b10, 4'd3, 4'd5, lat);
    chk("stall_latency", lat, 4);
    cmd_valid = 1'b1; cmd_oper = 2'b01; cmd_a = 4'd9; cmd_b = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_fields", {rsp_oper, rsp_result, rsp_status}, {2'b10, 4'd6, 3'd1});
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_cmd_ready", cmd_ready, 1);
    chk("b2b_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b_exec", {busy, rsp_valid}, 2'b10);
    chk("b2b_argA", argA, 9);
    chk("b2b_err", err_cnt, 1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", lat, 4);
    chk("b2b_result", rsp_result, 1);
    take_rsp();

    // Asynchronous reset in the middle of EXEC.
    cmd_valid = 1'b1; cmd_oper = 2'b01; cmd_a = 4'd8; cmd_b = 4'd1;
    @(negedge clk);
    chk("arst_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("arst_exe_out", {b_oper, b_argA, b_argB}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_err", err_cnt, 0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("arst_no_rsp", seen, 0);
    chk("arst_idle", busy, 0);

    // Random stream through the EXE_LAT=3 instance against an in-order scoreboard.
    sent = 0; rcvd = 0; nerr = 0;
    fork
      begin : drv
        bit acc;
        int gd;
        acc = 1'b0; gd = 0;
        while (sent < 1000 && gd < 40000) begin
          @(posedge clk); #1; gd++;
          if (acc) begin cmd_valid = 1'b0; acc = 1'b0; end
          if (!cmd_valid) begin
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_oper = 2'($urandom);
            if ($urandom_range(0, 2) != 0) begin
              sel_e = $urandom_range(0, 9);
              cmd_oper = (sel_e < 4) ? 2'b00 : (sel_e < 8) ? 2'b01 : (sel_e == 8) ? 2'b10 : 2'b11;
              cmd_valid = 1'b1;
            end
          end
          @(negedge clk);
          if (cmd_valid && cmd_ready) begin
            acc = 1'b1; sent++;
            q.push_back('{cmd_oper, cmd_a, cmd_b});
          end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
      end
      begin : rcv
        int gr;
        cmd_t e;
        logic [6:0] x;
        gr = 0;
        while (rcvd < 1000 && gr < 40000) begin
          @(posedge clk); #1; gr++;
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
              total++;
              $display("FAIL sb_extra_rsp: response %0d with no outstanding command", rcvd);
              rcvd++;
            end else begin
              e = q.pop_front();
              x = exe_fn(e.op, e.x, e.y, 1'b0);
              if (x[6:4] != STAT_OK) nerr++;
              chk("sb_result", rsp_result, x[3:0]);
              chk("sb_status", rsp_status, x[6:4]);
              chk("sb_oper", rsp_oper, e.op);
              chk("sb_err_cnt", err_cnt, (nerr > 255) ? 255 : nerr);
              rcvd++;
            end
          end
        end
        rsp_ready = 1'b0;
      end
    join
    chk("sb_sent", sent, 1000);
    chk("sb_rcvd", rcvd, 1000);
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
